// File: rtl/csa921_arb.sv
// rtl/csa921_arb.sv - round-robin scheduler sharing one 9:1 CSA tree, credit-protected in-order response FIFO
module csa921_arb #(
  parameter int NREQ  = 4,
  parameter int W     = 26,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic [NREQ*9*W-1:0]        req_ops_i,
  output logic [9*W-1:0]             tree_ops_o,
  input  logic [W-1:0]               tree_result_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [W-1:0]               rsp_data_o,
  output logic [$clog2(NREQ)-1:0]    rsp_id_o,
  output logic                       busy_o
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);

  logic [IDW-1:0]   rr_q, rr_d;
  logic [LAT-1:0]   sv_q;
  logic [IDW-1:0]   sid_q [LAT];
  logic [W+IDW-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q, wr_d, rd_d;
  logic [CW-1:0]    cnt_q;

  logic             pop, push, issue_ok, gnt_v;
  logic [IDW-1:0]   gnt_id;
  int               occ;
  int               idx;

  assign pop  = rsp_valid_o & rsp_ready_i;
  assign push = sv_q[LAT-1];

  // Every issue already in the tree owns a FIFO slot; a pop this cycle frees one immediately.
  always_comb begin
    occ = int'(cnt_q) - int'(pop);
    for (int s = 0; s < LAT; s++) begin
      occ = occ + int'(sv_q[s]);
    end
    issue_ok = rst_n && (occ < DEPTH);
  end

  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_v && issue_ok && req_valid_i[idx]) begin
        gnt_v  = 1'b1;
        gnt_id = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    tree_ops_o  = '0;
    rr_d        = rr_q;
    if (gnt_v) begin
      req_ready_o[gnt_id] = 1'b1;
      tree_ops_o          = req_ops_i[int'(gnt_id)*9*W +: 9*W];
      rr_d                = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
    end
  end

  always_comb begin
    wr_d = (int'(wr_q) == DEPTH - 1) ? '0 : wr_q + 1'b1;
    rd_d = (int'(rd_q) == DEPTH - 1) ? '0 : rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q  <= '0;
      sv_q  <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int s = 0; s < LAT; s++) sid_q[s] <= '0;
    end else begin
      rr_q     <= rr_d;
      sv_q     <= {sv_q[LAT-2:0], gnt_v};
      sid_q[0] <= gnt_id;
      for (int s = 1; s < LAT; s++) sid_q[s] <= sid_q[s-1];
      if (push) wr_q <= wr_d;
      if (pop)  rd_q <= rd_d;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_q] <= {tree_result_i, sid_q[LAT-1]};
  end

  assign rsp_valid_o = rst_n && (cnt_q != '0);
  assign rsp_data_o  = rsp_valid_o ? mem_q[rd_q][W+IDW-1:IDW] : '0;
  assign rsp_id_o    = rsp_valid_o ? mem_q[rd_q][IDW-1:0] : '0;
  assign busy_o      = rst_n && ((|sv_q) || (cnt_q != '0));

endmodule

// File: tb/tb_csa921_arb.sv
// tb/tb_csa921_arb.sv - randomized and directed bench for csa921_arb against a queue-based model
module tb_csa921_arb;
  localparam int NREQ = 4, W = 26, LAT = 3, DEPTH = 4, IDW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*9*W-1:0]  req_ops;
  logic [9*W-1:0]       tree_ops;
  logic [W-1:0]         tree_result, rsp_data;
  logic                 rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]       rsp_id;
  int                   checks = 0, failures = 0;

  always #5 clk = ~clk;

  csa921_arb #(.NREQ(NREQ), .W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_ops_i(req_ops),
    .tree_ops_o(tree_ops), .tree_result_i(tree_result),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_id_o(rsp_id), .busy_o(busy)
  );

  function automatic logic [W-1:0] sum9(input logic [9*W-1:0] v);
    logic [W-1:0] s;
    s = '0;
    for (int k = 0; k < 9; k++) s = s + v[k*W +: W];
    return s;
  endfunction

  // stand-in for the non-stallable adder tree: LAT-cycle pipelined sum, cleared by the shared reset
  logic [W-1:0] tp [LAT];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) tp[s] <= '0;
    end else begin
      tp[0] <= sum9(tree_ops);
      for (int s = 1; s < LAT; s++) tp[s] <= tp[s-1];
    end
  end
  assign tree_result = tp[LAT-1];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // model: every accepted set is an item that appears 4 cycles later and leaves on pop, in order
  typedef struct {
    logic [W-1:0] data;
    int           id;
    longint       due;
  } item_t;

  item_t            q[$];
  int               rr_m = 0;
  longint           cyc = 0;
  logic [NREQ-1:0]  acc = '0;

  always @(negedge clk) begin : cmp
    item_t          it;
    int             g, i;
    bit             pop_m, ok, head_v;
    logic [NREQ-1:0] exp_rdy;
    logic [9*W-1:0] exp_ops;
    cyc++;
    acc = req_valid & req_ready;
    if (!rst_n) begin
      q.delete();
      rr_m = 0;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_tree_ops", tree_ops, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
    end else begin
      head_v = (q.size() > 0) && (q[0].due <= cyc);
      pop_m  = head_v && rsp_ready;
      ok     = (q.size() - int'(pop_m)) < DEPTH;
      g = -1;
      if (ok) begin
        for (int k = 0; k < NREQ; k++) begin
          i = (rr_m + k) % NREQ;
          if (g < 0 && req_valid[i]) g = i;
        end
      end
      exp_rdy = '0;
      exp_ops = '0;
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        exp_ops    = req_ops[g*9*W +: 9*W];
      end
      chk("req_ready", req_ready, exp_rdy);
      chk("tree_ops", tree_ops, exp_ops);
      chk("rsp_valid", rsp_valid, head_v);
      if (head_v) begin
        chk("rsp_data", rsp_data, q[0].data);
        chk("rsp_id", rsp_id, q[0].id);
      end
      chk("busy", busy, q.size() > 0);
      if (pop_m) void'(q.pop_front());
      if (g >= 0) begin
        it.data = sum9(req_ops[g*9*W +: 9*W]);
        it.id   = g;
        it.due  = cyc + 4;
        q.push_back(it);
        rr_m = (g + 1) % NREQ;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_ops(input int i);
    for (int k = 0; k < 9; k++) req_ops[(i*9+k)*W +: W] = W'($urandom);
  endtask

  // requesters hold operands until accepted, then may offer a fresh set
  task automatic drive(input int pv);
    for (int i = 0; i < NREQ; i++) begin
      if (!req_valid[i] || acc[i]) begin
        req_valid[i] = ($urandom_range(99) < pv);
        new_ops(i);
      end
    end
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    req_valid = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic single_req(input int id, input bit ones, input logic [W-1:0] exp_sum);
    step();
    req_valid = '0;
    req_valid[id] = 1'b1;
    for (int k = 0; k < 9; k++) req_ops[(id*9+k)*W +: W] = ones ? {W{1'b1}} : W'(k + 1);
    @(negedge clk);
    chk("single_grant", req_ready, 1 << id);
    step();
    req_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_data", rsp_data, exp_sum);
    chk("single_rsp_id", rsp_id, id);
    @(negedge clk);
    chk("single_busy_clear", busy, 0);
  endtask

  int n_acc;

  initial begin
    rst_n = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) new_ops(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_tree_ops", tree_ops, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = '0;
    repeat (2) step();

    single_req(2, 1'b0, 26'd45);
    single_req(1, 1'b1, 26'h3FFFFF7);

    do_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) new_ops(i);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", req_ready, 1 << (k % 4));
      if (k >= 4) chk("rr_rsp_id", rsp_id, (k - 4) % 4);
      step();
      drive(100);
    end

    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    new_ops(0);
    n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ready[0]) n_acc++;
      chk("bp_ready", req_ready, (c < 4) ? 1 : 0);
      step();
      if (acc[0]) new_ops(0);
    end
    chk("bp_accept_count", n_acc, 4);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_reenable", req_ready, 1);
    chk("bp_rsp_valid", rsp_valid, 1);
    for (int c = 0; c < 20; c++) begin
      step();
      if (acc[0]) new_ops(0);
    end

    do_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) new_ops(i);
    repeat (3) begin
      step();
      drive(100);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(100);
    @(negedge clk);
    chk("midrst_grant0", req_ready, 1);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      chk("midrst_no_rsp", rsp_valid, 0);
      step();
      drive(100);
    end

    for (int c = 0; c < 3000; c++) begin
      step();
      drive(70);
      rsp_ready = ($urandom_range(99) < 60);
      rst_n = ($urandom_range(399) != 0);
    end
    step();
    rst_n = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (12) step();
    @(negedge clk);
    chk("drain_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/csa921_arb.md
# csa921_arb

Round-robin arbiter and scheduler that shares one free-running 9:1 carry-save adder tree (`csa_921`, 3-cycle latency) among `NREQ` requesters. Each requester offers nine `W`-bit operands with a valid/ready handshake. The arbiter issues at most one operand set per cycle and tracks each issue's requester ID through a shadow pipeline. Results return in issue order through a credit-protected response FIFO, so the non-stallable tree never drops a result.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `W`, 26: operand/result width; must match the tree.
- `LAT`, 3: tree latency in cycles, from operands presented to result visible.
- `DEPTH`, 4: response FIFO depth; must be ≥ `LAT`+1 for full throughput.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low; also drives the tree's `rst_n`.
- `req_valid`  in  `NREQ`  per-requester operand set valid.
- `req_ready`  out  `NREQ`  per-requester accept (one-hot or zero).
- `req_ops`  in  `NREQ*9*W`  operand k (0..8 = A0,A1,A2,B0,B1,B2,C0,C1,C2) of requester i at `[(i*9+k)*W +: W]`.
- `tree_ops`  out  `9*W`  to tree inputs, operand k at `[k*W +: W]`.
- `tree_result`  in  `W`  tree `result`.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accept.
- `rsp_data`  out  `W`  sum of the nine operands mod 2^W.
- `rsp_id`  out  `$clog2(NREQ)`  requester index of this response.
- `busy`  out  1  any shadow stage valid or FIFO non-empty.

## Operation
- Credit rule: `issue_ok = (fifo_count − pop) + v1 + v2 + v3 < DEPTH`, where `pop = rsp_valid & rsp_ready` and v1..v3 are the shadow-stage valids.
- Arbitration: if `issue_ok`, grant the first `i` with `req_valid[i]` set, searching from `rr_ptr` upward with wrap. `req_ready` = grant, combinational from `req_valid`, `rr_ptr` and the credit rule.
- Handshake: transfer when `req_valid[i] & req_ready[i]`. A requester holds `req_ops` stable while valid and not yet accepted.
- On grant: `tree_ops` = the granted requester's slice, the same cycle. `rr_ptr` ← grant+1 mod `NREQ`. Shadow stage 1 ← {1, id}.
- No grant: `tree_ops` = 0 and shadow stage 1 ← {0, x}.
- Shadow pipeline s1→s2→s3 advances every cycle, unconditionally. s3 valid aligns with the cycle its result is on `tree_result`.
- When s3 is valid, `{tree_result, s3.id}` is written into the FIFO at the end of that cycle. The credit rule guarantees no overflow. A simultaneous write and pop is legal.
- FIFO output drives `rsp_*` directly; `rsp_valid` = FIFO not empty. Responses leave in issue order.
- Arithmetic: `rsp_data` = Σ nine operands mod 2^W. The arbiter does no arithmetic and passes `tree_result` unaltered.
- Reset: `rr_ptr`=0; shadow valids, FIFO pointers and count cleared. In-flight results are discarded. Outputs at reset: `req_ready`=0, `tree_ops`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `busy`=0.

## Timing
- Request accepted in cycle t. `tree_result` is valid in cycle t+3, the FIFO is written at the end of t+3, and `rsp_valid` is high from t+4. Minimum latency is 4 cycles.
- Throughput is 1 issue/cycle sustained while `rsp_ready`=1 and `DEPTH` ≥ 4.
- With `rsp_ready`=0: at most `DEPTH` issues are outstanding, then every `req_ready` is 0. Each pop re-enables one issue in the same cycle, because the credit rule includes `pop`.
- `rsp_*` hold stable while `rsp_valid` & !`rsp_ready`.
- Reset asserted mid-operation: at the next edge all state is cleared. The tree's own registers also clear, so no stale result reaches the FIFO after reset.

## Test plan
- Reset: hold `rst_n`=0 with all `req_valid`=1 for 2 cycles → `req_ready`=0, `tree_ops`=0, `rsp_valid`=0, `busy`=0.
- Single request: requester 2 sends operands 1..9 at t=0 → `req_ready[2]`=1 at t=0; `rsp_valid`=1 at t=4 with `rsp_data`=45, `rsp_id`=2; `busy`=0 from t=5.
- Round robin: all 4 requesters continuously valid, `rsp_ready`=1 → grants 0,1,2,3,0,1… one per cycle; responses back-to-back from t=4 with IDs in the same order.
- Backpressure: `rsp_ready`=0, requester 0 continuously valid → exactly 4 accepted (t=0..3), then `req_ready`=0. Raise `rsp_ready` at t=10 → one new accept per pop; no response lost or duplicated.
- Wrap-around: all nine operands 0x3FFFFFF → `rsp_data`=0x3FFFFF7.
- Reset mid-flight: 3 issues outstanding, pulse `rst_n`=0 for 1 cycle → `rsp_valid` stays 0 for the next 4 cycles; the next grant goes to requester 0 when all are valid.
